// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
// Shared CPU constants for the writeback stage and register file.
//   DATA_W     : datapath width in bits
//   REG_ADDR_W : width of a register number
//   NUM_REGS   : number of architectural registers (register 0 is hardwired)
// Also provides the word/address types and the writeback source encoding.
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [DATA_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] regAddr_t;

    // Which pipeline value is written back: the ALU result or the load data.
    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wbSrc_e;

endpackage

// File: rtl/register_32.sv
// ---------------------------------------------------------------------------
// register_32
// One 32-bit architectural register with load enable.
//   clk_i  : clock, loads on the rising edge
//   rst_ni : asynchronous active-low clear
//   en_i   : load enable (already decoded for this register)
//   d_i    : value to load
//   q_o    : current contents
// ---------------------------------------------------------------------------
module register_32
    import wb_regfile_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/wb_select.sv
// ---------------------------------------------------------------------------
// wb_select
// Combinational writeback source mux.
//   memData_i   : load data from MEM/WB
//   aluResult_i : ALU result from MEM/WB
//   memToReg_i  : 1 selects memData_i, 0 selects aluResult_i
//   wbData_o    : selected writeback value
// ---------------------------------------------------------------------------
module wb_select
    import wb_regfile_pkg::*;
(
    input  logic [DATA_W-1:0] memData_i,
    input  logic [DATA_W-1:0] aluResult_i,
    input  logic              memToReg_i,
    output logic [DATA_W-1:0] wbData_o
);

    wbSrc_e wbSrc;

    // Decode the select bit into its meaning, then pick the source.
    always_comb begin
        wbSrc    = wbSrc_e'(memToReg_i);
        wbData_o = aluResult_i;
        case (wbSrc)
            WB_SRC_MEM: wbData_o = memData_i;
            default:    wbData_o = aluResult_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Writeback stage plus 32-entry register file with same-cycle bypass and a
// retired-write counter.
//   clk          : clock, state updates on the rising edge
//   reset        : asynchronous active-low reset
//   memDataIn    : load data from MEM/WB
//   aluResultIn  : ALU result from MEM/WB
//   writeRegIn   : destination register number
//   regWriteIn   : writeback request
//   memToRegIn   : 1 selects memDataIn, 0 selects aluResultIn
//   write        : stage enable, 0 suppresses commit and bypass
//   readRegA/B   : read addresses
//   readDataA/B  : read data (bypassed from wbDataOut when committing)
//   wbDataOut    : selected writeback value, for forwarding
//   retireCount  : number of committed register writes (wraps)
// ---------------------------------------------------------------------------
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     memDataIn,
    input  logic [DATA_W-1:0]     aluResultIn,
    input  logic [REG_ADDR_W-1:0] writeRegIn,
    input  logic                  regWriteIn,
    input  logic                  memToRegIn,
    input  logic                  write,
    input  logic [REG_ADDR_W-1:0] readRegA,
    input  logic [REG_ADDR_W-1:0] readRegB,
    output logic [DATA_W-1:0]     readDataA,
    output logic [DATA_W-1:0]     readDataB,
    output logic [DATA_W-1:0]     wbDataOut,
    output logic [DATA_W-1:0]     retireCount
);

    logic              commitEn;
    logic [DATA_W-1:0] regQ [NUM_REGS];
    logic [DATA_W-1:0] retireCount_q;
    logic [DATA_W-1:0] retireCount_d;

    wb_select u_wbSelect (
        .memData_i   (memDataIn),
        .aluResult_i (aluResultIn),
        .memToReg_i  (memToRegIn),
        .wbData_o    (wbDataOut)
    );

    // Reset is part of the qualifier so that bypass is also disabled while
    // reset is held, and an edge during reset cannot land a write.
    assign commitEn = write && regWriteIn && (writeRegIn != '0) && reset;

    assign regQ[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_regs
            register_32 u_reg (
                .clk_i  (clk),
                .rst_ni (reset),
                .en_i   (commitEn && (writeRegIn == REG_ADDR_W'(gi))),
                .d_i    (wbDataOut),
                .q_o    (regQ[gi])
            );
        end
    endgenerate

    // Read ports: a write committing this cycle is forwarded so the reader
    // sees the value it will hold after the edge.
    always_comb begin
        readDataA = regQ[readRegA];
        readDataB = regQ[readRegB];
        if (commitEn && (readRegA == writeRegIn)) begin
            readDataA = wbDataOut;
        end
        if (commitEn && (readRegB == writeRegIn)) begin
            readDataB = wbDataOut;
        end
    end

    always_comb begin
        retireCount_d = retireCount_q;
        if (commitEn) begin
            retireCount_d = retireCount_q + DATA_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retireCount_q <= '0;
        end else begin
            retireCount_q <= retireCount_d;
        end
    end

    assign retireCount = retireCount_q;

endmodule
